uart_tx_frame_timer: RTL and testbench
======================================

Name: uart_tx_frame_timer

Overview:
Parametrised successor to the fixed 9600-baud, fixed 10-bit TX bit timer. It sequences a complete UART TX frame (start, 5-8 data bits, optional parity, 1 or 2 stop bits) from a divisor and frame format latched at run time. It drives the TX shift/mux logic with a per-bit tick, the current phase and the bit index. It sits between the TX control FSM and the TX shift register.

Parameters:
DIV_W, 16, width of the baud divisor input and cycle counter
FRAC_W, 4, width of the fractional divisor input and accumulator (used only with FRAC_DIV_EN)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high; clears all state
start  input  1  request a frame; accepted when idle, or in the same cycle as done
abort  input  1  synchronous cancel of the frame in progress
div  input  DIV_W  clocks per bit; latched on accept; values 0 and 1 are treated as 2
frac  input  FRAC_W  fractional clocks per bit, in 1/2^FRAC_W units; latched on accept; ignored unless FRAC_DIV_EN
data_bits  input  2  0=5, 1=6, 2=7, 3=8 data bits; latched on accept
parity_en  input  1  insert one parity bit slot; latched on accept
stop2  input  1  0=1 stop bit, 1=2 stop bits; latched on accept
busy  output  1  frame in progress
baud_tick  output  1  one-cycle pulse on the last clock of every bit period
phase  output  2  0=IDLE, 1=START, 2=DATA, 3=PARITY; STOP is reported as 3 with stop_flag=1
stop_flag  output  1  high during stop bit(s)
bit_index  output  3  data bit number (LSB first, 0..n-1) in DATA; stop number (0..1) in STOP; 0 otherwise
done  output  1  one-cycle pulse coincident with the final baud_tick of the last stop bit

Behaviour:
- Reset: busy=0, baud_tick=0, phase=0, stop_flag=0, bit_index=0, done=0. Counter, accumulator and latched config are cleared. Reset has priority over start and abort and takes effect mid-frame without asserting done.
- States: IDLE -> START -> DATA -> (PARITY if parity_en) -> STOP -> IDLE.
- Accept: start=1 while idle, in cycle 0. Config is latched at that edge. From cycle 1: busy=1, phase=START, counter=0.
- Bit period is exactly div clocks, or div+1 clocks when the fractional carry applies. baud_tick is high on the last clock of each period. phase, stop_flag and bit_index advance at the edge that ends the tick cycle.
- First baud_tick is in cycle div (relative to accept in cycle 0).
- Frame length: div*(1+n+p+s) clocks, where n=5..8, p=0/1 and s=1/2.
- done=1 together with the final tick. busy=0 on the following cycle unless there is a back-to-back start.
- Back-to-back start (start=1 in the done cycle): the new config is latched, and the next cycle is START with counter=0, giving zero idle gap and keeping busy high.
- start while busy (other than in the done cycle) is ignored. Config input changes while busy have no effect.
- abort=1 while busy: next cycle is IDLE with all outputs at reset values and no done pulse. abort while idle has no effect. If abort and start are both high in the same cycle, abort wins and the start is dropped.
- Counter is DIV_W bits and never overflows, because the maximum count is div, which is at most 2^DIV_W-1.

Optional Feature:
FRAC_DIV_EN.
- Defined: the accumulator (FRAC_W bits) is cleared on accept. At the end of every bit period, acc <= acc + frac. A carry out makes the next bit period div+1 clocks; no carry makes it div clocks. The first bit period is always div.
- Undefined: the frac port is present but ignored, no accumulator is built, and every bit period is exactly div clocks.

Test Plan:
- div=4, data_bits=3, parity_en=0, stop2=0, start pulse -> ticks at cycles 4,8,...,40; DATA bit_index 0..7; done at cycle 40; busy=0 at cycle 41.
- div=3, data_bits=2, parity_en=1, stop2=1 -> 11 bits; PARITY during cycles 25-27; stop bit_index 0 then 1; done at cycle 33.
- 8N1 div=4 frame with start held high at done -> second frame START begins cycle 41, busy stays 1, second done at cycle 80; start pulse at cycle 10 ignored.
- div=5 8N1, abort at cycle 17 (DATA bit 2) -> cycle 18 idle, all outputs 0, done never pulses; a new start is accepted at cycle 18.
- div=1 8N1 -> treated as 2, done at cycle 20. Separately, reset at cycle 7 of a frame -> cycle 8 all outputs 0, no done.
- FRAC_DIV_EN, FRAC_W=4, div=4, frac=8, 8N1 -> bits 2,4,6,8 last 5 clocks, all other bits 4 clocks; done at cycle 44. Without the macro, the same stimulus gives done at cycle 40.

Source files
------------

// File: rtl/uart_tx_frame_timer_if.sv
// uart_tx_frame_timer_if: control/config inputs and frame timing outputs
// shared between the TX control FSM (master) and the frame timer (slave).
interface uart_tx_frame_timer_if #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
);
    logic              start;
    logic              abort;
    logic [DIV_W-1:0]  div;
    logic [FRAC_W-1:0] frac;
    logic [1:0]        data_bits;
    logic              parity_en;
    logic              stop2;
    logic              busy;
    logic              baud_tick;
    logic [1:0]        phase;
    logic              stop_flag;
    logic [2:0]        bit_index;
    logic              done;

    modport master (
        output start, abort, div, frac, data_bits, parity_en, stop2,
        input  busy, baud_tick, phase, stop_flag, bit_index, done
    );

    modport slave (
        input  start, abort, div, frac, data_bits, parity_en, stop2,
        output busy, baud_tick, phase, stop_flag, bit_index, done
    );
endinterface

// File: rtl/uart_tx_frame_timer.sv
// uart_tx_frame_timer: sequences one UART TX frame (start, 5-8 data bits,
// optional parity, 1-2 stop bits) from a divisor and format latched when the
// frame is accepted. Emits a tick on the last clock of every bit period plus
// the current phase / bit index for the TX shift and mux logic.
// Optional build macro FRAC_DIV_EN adds a fractional divisor accumulator that
// stretches selected bit periods by one clock.
module uart_tx_frame_timer #(
    parameter int DIV_W  = 16,
    parameter int FRAC_W = 4
) (
    input logic                 clk,
    input logic                 reset,
    uart_tx_frame_timer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_nx;
    logic [DIV_W-1:0] cnt_q, cnt_nx;
    logic [DIV_W-1:0] div_q, div_nx;
    logic [2:0]       bidx_q, bidx_nx;
    logic [1:0]       dbits_q, dbits_nx;
    logic             par_q, par_nx;
    logic             stop2_q, stop2_nx;
    logic             extra_q;

    logic [DIV_W-1:0] last_cnt;
    logic             active;
    logic             tick;
    logic             last_stop;
    logic             frame_done;
    logic             accept;

`ifdef FRAC_DIV_EN
    logic [FRAC_W-1:0] frac_q, frac_nx;
    logic [FRAC_W-1:0] acc_q, acc_nx;
    logic              extra_nx;
    logic [FRAC_W:0]   acc_sum;

    // Carry out of the fractional accumulator lengthens the next bit period.
    assign acc_sum = {1'b0, acc_q} + {1'b0, frac_q};
`else
    // Without the fractional divisor every bit period is exactly div clocks.
    assign extra_q = 1'b0;
`endif

    // The bit period ends when the counter reaches div-1, or div when stretched.
    assign active     = (state_q != S_IDLE);
    assign last_cnt   = div_q - DIV_W'(1) + DIV_W'(extra_q);
    assign tick       = active && (cnt_q == last_cnt);
    assign last_stop  = (bidx_q == {2'b00, stop2_q});
    assign frame_done = tick && (state_q == S_STOP) && last_stop;
    // A new frame may start while idle or in the very cycle the last one ends.
    assign accept     = bus.start && !bus.abort && (!active || frame_done);

    // State, counter and latched configuration registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bidx_q  <= '0;
            dbits_q <= '0;
            par_q   <= 1'b0;
            stop2_q <= 1'b0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            div_q   <= div_nx;
            bidx_q  <= bidx_nx;
            dbits_q <= dbits_nx;
            par_q   <= par_nx;
            stop2_q <= stop2_nx;
        end
    end

`ifdef FRAC_DIV_EN
    // Fractional divisor, accumulator and stretch flag registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            frac_q  <= '0;
            acc_q   <= '0;
            extra_q <= 1'b0;
        end else begin
            frac_q  <= frac_nx;
            acc_q   <= acc_nx;
            extra_q <= extra_nx;
        end
    end
`endif

    // Next-state logic: abort beats accept, accept beats normal sequencing.
    always_comb begin
        state_nx = state_q;
        cnt_nx   = cnt_q;
        div_nx   = div_q;
        bidx_nx  = bidx_q;
        dbits_nx = dbits_q;
        par_nx   = par_q;
        stop2_nx = stop2_q;
`ifdef FRAC_DIV_EN
        frac_nx  = frac_q;
        acc_nx   = acc_q;
        extra_nx = extra_q;
`endif
        if (active && bus.abort) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
            bidx_nx  = '0;
`ifdef FRAC_DIV_EN
            acc_nx   = '0;
            extra_nx = 1'b0;
`endif
        end else if (accept) begin
            state_nx = S_START;
            cnt_nx   = '0;
            bidx_nx  = '0;
            // Divisors below 2 would leave no room for a distinct tick cycle.
            div_nx   = (bus.div < DIV_W'(2)) ? DIV_W'(2) : bus.div;
            dbits_nx = bus.data_bits;
            par_nx   = bus.parity_en;
            stop2_nx = bus.stop2;
`ifdef FRAC_DIV_EN
            frac_nx  = bus.frac;
            acc_nx   = '0;
            extra_nx = 1'b0;
`endif
        end else if (active) begin
            if (tick) begin
                cnt_nx = '0;
`ifdef FRAC_DIV_EN
                acc_nx   = acc_sum[FRAC_W-1:0];
                extra_nx = acc_sum[FRAC_W];
`endif
                unique case (state_q)
                    S_START: begin
                        state_nx = S_DATA;
                        bidx_nx  = '0;
                    end
                    S_DATA: begin
                        if (bidx_q == ({1'b0, dbits_q} + 3'd4)) begin
                            state_nx = par_q ? S_PARITY : S_STOP;
                            bidx_nx  = '0;
                        end else begin
                            bidx_nx = bidx_q + 3'd1;
                        end
                    end
                    S_PARITY: begin
                        state_nx = S_STOP;
                        bidx_nx  = '0;
                    end
                    S_STOP: begin
                        if (last_stop) begin
                            state_nx = S_IDLE;
                            bidx_nx  = '0;
                        end else begin
                            bidx_nx = bidx_q + 3'd1;
                        end
                    end
                    default: begin
                        state_nx = S_IDLE;
                    end
                endcase
            end else begin
                cnt_nx = cnt_q + DIV_W'(1);
            end
        end
    end

    // Phase encoding: stop bits share code 3 with parity, told apart by stop_flag.
    always_comb begin
        bus.phase = 2'd0;
        unique case (state_q)
            S_START:  bus.phase = 2'd1;
            S_DATA:   bus.phase = 2'd2;
            S_PARITY: bus.phase = 2'd3;
            S_STOP:   bus.phase = 2'd3;
            default:  bus.phase = 2'd0;
        endcase
    end

    assign bus.busy      = active;
    assign bus.baud_tick = tick;
    assign bus.stop_flag = (state_q == S_STOP);
    assign bus.bit_index = bidx_q;
    assign bus.done      = frame_done;

endmodule

// File: tb/tb_uart_tx_frame_timer.sv
// tb_uart_tx_frame_timer: directed frames; expected ticks are queued when a
// frame is started and a monitor pops one entry on every baud_tick.
module tb_uart_tx_frame_timer;
    localparam int DIV_W  = 16;
    localparam int FRAC_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;

    uart_tx_frame_timer_if #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus();

    uart_tx_frame_timer #(.DIV_W(DIV_W), .FRAC_W(FRAC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int ph;
        int sf;
        int idx;
        int dn;
    } tick_t;

    tick_t q[$];
    tick_t mon_e;
    int base = 0;
    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int last_done = -1;
    int dc0 = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (rel cycle %0d)", name, act, exp, cyc - base);
        end
    endfunction

    // Monitor: every tick must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.done && !bus.baud_tick) chk("done_without_tick", 1, 0);
            if (bus.baud_tick) begin
                if (q.size() == 0) begin
                    chk("unexpected_tick", cyc - base, -1);
                end else begin
                    mon_e = q.pop_front();
                    chk("tick_cycle", cyc - base, mon_e.c);
                    chk("tick_phase", int'(bus.phase), mon_e.ph);
                    chk("tick_stop_flag", int'(bus.stop_flag), mon_e.sf);
                    chk("tick_bit_index", int'(bus.bit_index), mon_e.idx);
                    chk("tick_done", int'(bus.done), mon_e.dn);
                end
                if (bus.done) begin
                    done_cnt++;
                    last_done = cyc - base;
                end
            end
        end
    end

    // Queue the ticks of one frame whose accept cycle is 'off'; ticks at or
    // beyond 'limit' are not expected (frame cut short).
    task automatic push_frame(int off, int d, int db, int p, int s, int f, int limit);
        int n, nb, t, de, extra, acc;
        tick_t e;
        n = db + 5;
        nb = 1 + n + p + s + 1;
        de = (d < 2) ? 2 : d;
        t = off;
        extra = 0;
        acc = 0;
        for (int b = 0; b < nb; b++) begin
            t = t + de + extra;
            e.c = t;
            e.sf = 0;
            e.idx = 0;
            e.dn = 0;
            if (b == 0) begin
                e.ph = 1;
            end else if (b <= n) begin
                e.ph = 2;
                e.idx = b - 1;
            end else if (p != 0 && b == n + 1) begin
                e.ph = 3;
            end else begin
                e.ph = 3;
                e.sf = 1;
                e.idx = b - (1 + n + p);
                e.dn = (b == nb - 1) ? 1 : 0;
            end
            if (t < limit) q.push_back(e);
`ifdef FRAC_DIV_EN
            acc = acc + f;
            if (acc >= (1 << FRAC_W)) begin
                extra = 1;
                acc = acc - (1 << FRAC_W);
            end else begin
                extra = 0;
            end
`else
            extra = f * 0;
            acc = 0;
`endif
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic goto(int k);
        while (cyc - base < k) step();
    endtask

    task automatic kick(int d, int db, int p, int s, int f);
        bus.div = DIV_W'(d);
        bus.data_bits = 2'(db);
        bus.parity_en = p[0];
        bus.stop2 = s[0];
        bus.frac = FRAC_W'(f);
        bus.start = 1'b1;
    endtask

    task automatic check_idle(string tag);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_tick"}, int'(bus.baud_tick), 0);
        chk({tag, "_phase"}, int'(bus.phase), 0);
        chk({tag, "_stop_flag"}, int'(bus.stop_flag), 0);
        chk({tag, "_bit_index"}, int'(bus.bit_index), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.div = '0;
        bus.frac = '0;
        bus.data_bits = '0;
        bus.parity_en = 1'b0;
        bus.stop2 = 1'b0;
        reset = 1'b1;
        repeat (3) step();
        check_idle("reset");
        reset = 1'b0;
        step();

        // 8N1, div=4: done at 40, idle at 41
        kick(4, 3, 0, 0, 0);
        base = cyc;
        push_frame(0, 4, 3, 0, 0, 0, 100000);
        step();
        bus.start = 1'b0;
        chk("t1_busy_c1", int'(bus.busy), 1);
        chk("t1_phase_c1", int'(bus.phase), 1);
        goto(41);
        chk("t1_busy_c41", int'(bus.busy), 0);
        chk("t1_done_cycle", last_done, 40);
        chk("t1_queue_left", q.size(), 0);
        step();

        // 7E2, div=3: parity in 25-27, second stop from 31, done at 33
        kick(3, 2, 1, 1, 0);
        base = cyc;
        push_frame(0, 3, 2, 1, 1, 0, 100000);
        step();
        bus.start = 1'b0;
        goto(26);
        chk("t2_phase_parity", int'(bus.phase), 3);
        chk("t2_sf_parity", int'(bus.stop_flag), 0);
        goto(31);
        chk("t2_sf_stop1", int'(bus.stop_flag), 1);
        chk("t2_idx_stop1", int'(bus.bit_index), 1);
        goto(34);
        chk("t2_done_cycle", last_done, 33);
        chk("t2_busy_c34", int'(bus.busy), 0);
        chk("t2_queue_left", q.size(), 0);
        step();

        // back-to-back frames; start with a different config at 10 is ignored
        dc0 = done_cnt;
        kick(4, 3, 0, 0, 0);
        base = cyc;
        push_frame(0, 4, 3, 0, 0, 0, 100000);
        push_frame(40, 4, 3, 0, 0, 0, 100000);
        step();
        bus.start = 1'b0;
        goto(10);
        kick(7, 0, 1, 1, 0);
        step();
        bus.start = 1'b0;
        goto(40);
        chk("t3_done_c40", int'(bus.done), 1);
        kick(4, 3, 0, 0, 0);
        step();
        bus.start = 1'b0;
        chk("t3_busy_c41", int'(bus.busy), 1);
        chk("t3_phase_c41", int'(bus.phase), 1);
        goto(81);
        chk("t3_done_cycle", last_done, 80);
        chk("t3_done_count", done_cnt - dc0, 2);
        chk("t3_busy_c81", int'(bus.busy), 0);
        chk("t3_queue_left", q.size(), 0);
        step();

        // abort in DATA bit 2, then restart at 18
        dc0 = done_cnt;
        kick(5, 3, 0, 0, 0);
        base = cyc;
        push_frame(0, 5, 3, 0, 0, 0, 17);
        step();
        bus.start = 1'b0;
        goto(17);
        chk("t4_idx_c17", int'(bus.bit_index), 2);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check_idle("t4_abort");
        kick(5, 3, 0, 0, 0);
        push_frame(18, 5, 3, 0, 0, 0, 100000);
        step();
        bus.start = 1'b0;
        goto(69);
        chk("t4_done_cycle", last_done, 68);
        chk("t4_done_count", done_cnt - dc0, 1);
        chk("t4_queue_left", q.size(), 0);
        step();

        // div=1 behaves as 2
        kick(1, 3, 0, 0, 0);
        base = cyc;
        push_frame(0, 1, 3, 0, 0, 0, 100000);
        step();
        bus.start = 1'b0;
        goto(21);
        chk("t5_done_cycle", last_done, 20);
        chk("t5_busy_c21", int'(bus.busy), 0);
        step();

        // reset mid-frame at cycle 7
        kick(4, 3, 0, 0, 0);
        base = cyc;
        push_frame(0, 4, 3, 0, 0, 0, 7);
        step();
        bus.start = 1'b0;
        goto(7);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("t5_reset");
        dc0 = done_cnt;
        goto(50);
        chk("t5_reset_no_done", done_cnt - dc0, 0);
        chk("t5_queue_left", q.size(), 0);

        // fractional divisor frac=8/16
        kick(4, 3, 0, 0, 8);
        base = cyc;
        push_frame(0, 4, 3, 0, 0, 8, 100000);
        step();
        bus.start = 1'b0;
        bus.frac = '0;
        goto(50);
`ifdef FRAC_DIV_EN
        chk("t6_done_cycle", last_done, 44);
`else
        chk("t6_done_cycle", last_done, 40);
`endif
        chk("t6_queue_left", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
